// File: rtl/register_write_pkg.sv
// rtl/register_write_pkg.sv - shared encodings for the register write arbiter
// Purpose: FSM state encoding, grant encoding and default limits used by the
//          arbiter and its starvation counter.
// Ports:   none (package).
package register_write_pkg;

  // FSM state encoding kept as plain constants so the sweep/run split maps
  // directly onto a single flop.
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'd0,
    GRANT_WB   = 2'd1,
    GRANT_MC   = 2'd2
  } grant_t;

  localparam int DEFAULT_STARVE_LIMIT = 4;
  localparam int STARVE_COUNT_WIDTH   = 4;

endpackage

// File: rtl/register_write_arbiter_if.sv
// rtl/register_write_arbiter_if.sv - requester and register-file bus of the write arbiter
// Purpose: groups the WB and MC request handshakes and the register-file write
//          port into one bundle.
// Ports:   master - requester/register-file side (drives valid/address/data)
//          slave  - arbiter side (drives readys, write port and init_done)
interface register_write_arbiter_if #(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_SIZE  = $clog2(REGISTER_SIZE)
);

  logic                     wb_valid;
  logic                     wb_ready;
  logic [ADDRESS_SIZE-1:0]  wb_address;
  logic [REGISTER_SIZE-1:0] wb_data;

  logic                     mc_valid;
  logic                     mc_ready;
  logic [ADDRESS_SIZE-1:0]  mc_address;
  logic [REGISTER_SIZE-1:0] mc_data;

  logic                     write_enable;
  logic [ADDRESS_SIZE-1:0]  write_address;
  logic [REGISTER_SIZE-1:0] write_data;
  logic                     init_done;

  modport master (
    output wb_valid, wb_address, wb_data,
    output mc_valid, mc_address, mc_data,
    input  wb_ready, mc_ready,
    input  write_enable, write_address, write_data, init_done
  );

  modport slave (
    input  wb_valid, wb_address, wb_data,
    input  mc_valid, mc_address, mc_data,
    output wb_ready, mc_ready,
    output write_enable, write_address, write_data, init_done
  );

endinterface

// File: rtl/write_starvation_counter.sv
// rtl/write_starvation_counter.sv - saturating count of WB grants taken while MC waits
// Purpose: counts consecutive WB grants that overtook a waiting MC request and
//          flags when MC must be served next.
// Ports:   clk_i, rst_ni  - clock, asynchronous active-low reset
//          clear_i        - zero the count (MC granted or MC not waiting)
//          inc_i          - one more WB grant while MC waits
//          starved_o      - count has reached LIMIT
module write_starvation_counter
  import register_write_pkg::*;
#(
  parameter int LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic inc_i,
  output logic starved_o
);

  localparam logic [STARVE_COUNT_WIDTH-1:0] LIMIT_L = STARVE_COUNT_WIDTH'(LIMIT);

  logic [STARVE_COUNT_WIDTH-1:0] count_q;
  logic [STARVE_COUNT_WIDTH-1:0] count_d;

  // Clear wins over increment; the count parks at LIMIT until MC is served.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != LIMIT_L)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign starved_o = (count_q == LIMIT_L);

endmodule

// File: rtl/register_write_arbiter.sv
// rtl/register_write_arbiter.sv - clear sweep and WB/MC arbitration for the register-file write port
// Purpose: after reset writes zero to registers 1..REGISTER_SIZE-1, then shares
//          the single write port between WB (preferred) and MC, with a
//          starvation guard bounding MC wait.
// Ports:   system_clock    - rising-edge clock
//          system_reset_n  - asynchronous active-low reset
//          bus (slave)     - WB/MC handshakes, register-file write port, init_done
module register_write_arbiter
  import register_write_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int ADDRESS_SIZE  = $clog2(REGISTER_SIZE),
  parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
  input logic                    system_clock,
  input logic                    system_reset_n,
  register_write_arbiter_if.slave bus
);

  localparam logic [ADDRESS_SIZE-1:0] FIRST_ADDR = ADDRESS_SIZE'(1);
  localparam logic [ADDRESS_SIZE-1:0] LAST_ADDR  = ADDRESS_SIZE'(REGISTER_SIZE - 1);

  logic [0:0]              state_q;
  logic [0:0]              state_d;
  logic [ADDRESS_SIZE-1:0] clear_ptr_q;
  logic [ADDRESS_SIZE-1:0] clear_ptr_d;

  grant_t                   grant;
  logic                     starved;
  logic                     wb_ready_c;
  logic                     mc_ready_c;
  logic                     write_enable_c;
  logic [ADDRESS_SIZE-1:0]  write_address_c;
  logic [REGISTER_SIZE-1:0] write_data_c;
  logic                     init_done_c;

  // Grant is only issued in RUN and outside reset; MC overtakes WB once the
  // starvation guard trips.
  always_comb begin
    grant = GRANT_NONE;
    if (system_reset_n && (state_q == RUN)) begin
      if (bus.mc_valid && (!bus.wb_valid || starved)) begin
        grant = GRANT_MC;
      end else if (bus.wb_valid) begin
        grant = GRANT_WB;
      end
    end
  end

  // Outputs are gated by reset directly so the port is quiet while reset is
  // held, even though CLEAR would otherwise drive a write.
  always_comb begin
    wb_ready_c      = 1'b0;
    mc_ready_c      = 1'b0;
    write_enable_c  = 1'b0;
    write_address_c = '0;
    write_data_c    = '0;
    init_done_c     = 1'b0;
    if (!system_reset_n) begin
      init_done_c = 1'b0;
    end else if (state_q == CLEAR) begin
      write_enable_c  = 1'b1;
      write_address_c = clear_ptr_q;
    end else begin
      init_done_c = 1'b1;
      case (grant)
        GRANT_WB: begin
          wb_ready_c      = 1'b1;
          write_address_c = bus.wb_address;
          write_data_c    = bus.wb_data;
          // Register 0 is hard-wired zero: accept the request, suppress the write.
          write_enable_c  = (bus.wb_address != '0);
        end
        GRANT_MC: begin
          mc_ready_c      = 1'b1;
          write_address_c = bus.mc_address;
          write_data_c    = bus.mc_data;
          write_enable_c  = (bus.mc_address != '0);
        end
        default: begin
          write_enable_c = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == CLEAR) begin
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (clear_ptr_q == LAST_ADDR) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge system_clock or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q     <= CLEAR;
      clear_ptr_q <= FIRST_ADDR;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  write_starvation_counter #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk_i    (system_clock),
    .rst_ni   (system_reset_n),
    .clear_i  (!bus.mc_valid || (grant == GRANT_MC)),
    .inc_i    (grant == GRANT_WB),
    .starved_o(starved)
  );

  assign bus.wb_ready      = wb_ready_c;
  assign bus.mc_ready      = mc_ready_c;
  assign bus.write_enable  = write_enable_c;
  assign bus.write_address = write_address_c;
  assign bus.write_data    = write_data_c;
  assign bus.init_done     = init_done_c;

endmodule

// File: tb/tb_register_write_arbiter.sv
// tb/tb_register_write_arbiter.sv - self-checking bench for register_write_arbiter
module tb_register_write_arbiter;

  localparam int RS    = 32;
  localparam int AS    = 5;
  localparam int LIMIT = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  register_write_arbiter_if #(.REGISTER_SIZE(RS), .ADDRESS_SIZE(AS)) bus ();

  register_write_arbiter #(
    .REGISTER_SIZE(RS),
    .ADDRESS_SIZE (AS),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .system_clock  (clk),
    .system_reset_n(rst_n),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register contents as captured from the DUT write port, and as predicted.
  logic [31:0] rf     [0:RS-1];
  logic [31:0] m_regs [0:RS-1];
  byte         glog[$];
  int          rel_cyc;
  int          first_init;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model of the arbiter from its rules: sweep position, MC wait count, register image.
  initial begin
    int          m_sweep;
    int          m_wait;
    bit          mc_turn;
    bit          wb_turn;
    logic        e_we, e_wbr, e_mcr, e_init;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    m_sweep    = 1;
    m_wait     = 0;
    rel_cyc    = 0;
    first_init = 0;
    for (int i = 0; i < RS; i++) begin
      rf[i]     = (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
      m_regs[i] = (i == 0) ? 32'h0 : 32'hFFFF_FFFF;
    end
    forever begin
      @(negedge clk);
      e_we = 0; e_wbr = 0; e_mcr = 0; e_init = 0; e_addr = '0; e_data = '0;
      if (!rst_n) begin
        m_sweep    = 1;
        m_wait     = 0;
        rel_cyc    = 0;
        first_init = 0;
      end else begin
        rel_cyc++;
        if (m_sweep <= RS - 1) begin
          e_we   = 1;
          e_addr = 5'(m_sweep);
          m_sweep++;
        end else begin
          e_init  = 1;
          mc_turn = bus.mc_valid && (!bus.wb_valid || (m_wait >= LIMIT));
          wb_turn = !mc_turn && bus.wb_valid;
          if (mc_turn) begin
            e_mcr = 1; e_addr = bus.mc_address; e_data = bus.mc_data;
          end else if (wb_turn) begin
            e_wbr = 1; e_addr = bus.wb_address; e_data = bus.wb_data;
          end
          e_we = (mc_turn || wb_turn) && (e_addr != 0);
          if (!bus.mc_valid || mc_turn) m_wait = 0;
          else if (wb_turn && m_wait < LIMIT) m_wait++;
        end
        if (e_we) m_regs[e_addr] = e_data;
        if (bus.write_enable) rf[bus.write_address] = bus.write_data;
        if (bus.init_done && first_init == 0) first_init = rel_cyc;
        glog.push_back(bus.wb_ready ? 8'h57 : (bus.mc_ready ? 8'h4D : 8'h2D));
      end
      chk("cyc_we",    32'(bus.write_enable),  32'(e_we));
      chk("cyc_addr",  32'(bus.write_address), 32'(e_addr));
      chk("cyc_data",  bus.write_data,         e_data);
      chk("cyc_wbr",   32'(bus.wb_ready),      32'(e_wbr));
      chk("cyc_mcr",   32'(bus.mc_ready),      32'(e_mcr));
      chk("cyc_init",  32'(bus.init_done),     32'(e_init));
    end
  end

  task automatic issue(input bit wv, input logic [4:0] wa, input logic [31:0] wd,
                       input bit mv, input logic [4:0] ma, input logic [31:0] md,
                       output int cycles);
    bit wpend, mpend, wacc, macc;
    wpend = wv; mpend = mv; cycles = 0;
    bus.wb_valid = wv; bus.wb_address = wa; bus.wb_data = wd;
    bus.mc_valid = mv; bus.mc_address = ma; bus.mc_data = md;
    while ((wpend || mpend) && cycles < 40) begin
      @(negedge clk);
      wacc = bus.wb_valid && bus.wb_ready;
      macc = bus.mc_valid && bus.mc_ready;
      step();
      cycles++;
      if (wacc) begin wpend = 0; bus.wb_valid = 0; end
      if (macc) begin mpend = 0; bus.mc_valid = 0; end
    end
    total++;
    if (wpend || mpend) begin
      bad++;
      $display("FAIL issue_timeout: pending wb=%0d mc=%0d after %0d cycles", wpend, mpend, cycles);
    end
  endtask

  initial begin
    int    n;
    int    idx;
    int    nz;
    string pat;
    total = 0;
    bad   = 0;
    rst_n = 0;
    bus.wb_valid = 0; bus.wb_address = '0; bus.wb_data = '0;
    bus.mc_valid = 0; bus.mc_address = '0; bus.mc_data = '0;
    repeat (2) step();
    @(negedge clk); #2;
    chk("rst_we",   32'(bus.write_enable), 32'd0);
    chk("rst_init", 32'(bus.init_done),    32'd0);
    chk("rst_addr", 32'(bus.write_address), 32'd0);
    step();
    rst_n = 1;

    // Clear sweep with no requests.
    repeat (31) step();
    @(negedge clk); #2;
    chk("init_cycle", 32'(first_init), 32'd32);
    nz = 0;
    for (int i = 1; i < RS; i++) if (rf[i] !== 32'h0) nz++;
    chk("sweep_zero", 32'(nz), 32'd0);
    chk("reg0_after_sweep", rf[0], 32'h0);
    step();

    issue(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, n);
    chk("reg5", rf[5], 32'hDEAD_BEEF);
    chk("wb_alone_latency", 32'(n), 32'd1);

    issue(1, 5'd0, 32'h0000_1234, 0, 5'd0, 32'h0, n);
    chk("reg0", rf[0], 32'h0);
    step();

    issue(1, 5'd7, 32'hAAAA_0000, 1, 5'd7, 32'h5555_FFFF, n);
    chk("reg7", rf[7], 32'h5555_FFFF);
    chk("same_addr_first", 32'(glog[glog.size()-2]), 32'h57);
    chk("same_addr_second", 32'(glog[glog.size()-1]), 32'h4D);
    step();

    // Both continuously valid: MC served every LIMIT+1 cycles.
    idx = glog.size();
    bus.wb_valid = 1; bus.wb_address = 5'd10; bus.wb_data = 32'h0A0A_0A0A;
    bus.mc_valid = 1; bus.mc_address = 5'd11; bus.mc_data = 32'h0B0B_0B0B;
    repeat (10) step();
    bus.wb_valid = 0; bus.mc_valid = 0;
    pat = "WWWWMWWWWM";
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pattern_%0d", i), 32'(glog[idx+i]), 32'(pat[i]));
    end

    issue(0, 5'd0, 32'h0, 1, 5'd12, 32'hC0C0_C0C0, n);
    chk("mc_alone_latency", 32'(n), 32'd1);
    chk("reg12", rf[12], 32'hC0C0_C0C0);

    // Reset in RUN, then again mid-sweep at address 16.
    rst_n = 0;
    step();
    rst_n = 1;
    repeat (15) step();
    chk("sweep_addr16", 32'(bus.write_address), 32'd16);
    rst_n = 0;
    step();
    step();
    bus.wb_valid = 1; bus.wb_address = 5'd9; bus.wb_data = 32'h0000_0099;
    rst_n = 1;
    n = 0;
    while (n < 60) begin
      @(negedge clk);
      n++;
      if (bus.wb_ready) break;
    end
    step();
    bus.wb_valid = 0;
    chk("held_off_until_run", 32'(n), 32'd32);
    chk("init_cycle_after_restart", 32'(first_init), 32'd32);
    step();
    chk("reg9", rf[9], 32'h0000_0099);
    chk("reg5_cleared", rf[5], 32'h0);

    for (int i = 0; i < RS; i++) begin
      chk($sformatf("final_reg%0d", i), rf[i], m_regs[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_write_arbiter.md
# register_write_arbiter

Sequencer and arbiter for the single write port of `general_purpose_register`. After reset it sweeps zeros into every register, then shares the port between two requesters:
- the pipeline writeback stage (WB, normally preferred);
- a multi-cycle execution unit (MC, e.g. mult/div result return).

A starvation guard bounds MC wait time. Outputs drive the register file's `write_enable`/`write_address`/`write_data` directly.

## Interface
Parameters:
- REGISTER_SIZE, 32, data width and register count (matches register file)
- ADDRESS_SIZE, $clog2(REGISTER_SIZE), address width
- STARVE_LIMIT, 4, max consecutive WB grants while MC waits; range 1..15

Ports:
- system_clock  in  1  single clock, rising edge
- system_reset_n  in  1  asynchronous, active-low reset
- wb_valid  in  1  WB write request
- wb_ready  out  1  WB request accepted this cycle
- wb_address  in  ADDRESS_SIZE  WB destination
- wb_data  in  REGISTER_SIZE  WB value
- mc_valid  in  1  MC write request
- mc_ready  out  1  MC request accepted this cycle
- mc_address  in  ADDRESS_SIZE  MC destination
- mc_data  in  REGISTER_SIZE  MC value
- write_enable  out  1  to register file
- write_address  out  ADDRESS_SIZE  to register file
- write_data  out  REGISTER_SIZE  to register file
- init_done  out  1  high once clear sweep complete

## Operation
- FSM states: CLEAR, RUN. Reset forces CLEAR with clear_ptr=1 and starve_count=0.
- While reset is asserted: write_enable=0, wb_ready=0, mc_ready=0, init_done=0, write_address=0, write_data=0.
- CLEAR:
  - write_enable=1, write_address=clear_ptr, write_data=0; both readys low.
  - clear_ptr increments each cycle.
  - After writing REGISTER_SIZE-1, go to RUN.
  - Address 0 is never written (it is hard-wired zero in the register file).
- RUN, init_done=1. Grant rule, evaluated each cycle:
  - MC is granted if mc_valid and (not wb_valid, or starve_count==STARVE_LIMIT).
  - Otherwise WB is granted if wb_valid.
  - Exactly one ready can be high, and only for a requester whose valid is high. A ready is never high without its valid.
- Handshake completes on the rising edge where valid&&ready.
  - Requesters hold address/data stable while valid is high and ready is low.
  - Requesters do not drop valid before acceptance.
- Write path, on grant:
  - write_address and write_data are the granted requester's inputs.
  - write_enable=1 unless the granted address is 0. For address 0 the handshake still completes and write_enable=0.
  - No grant: write_enable=0; address/data are don't-care, driven 0.
- starve_count, 4-bit:
  - +1 on each WB grant while mc_valid is high.
  - Cleared on any MC grant, or in any cycle mc_valid is low.
  - Saturates at STARVE_LIMIT.
- Same-address simultaneous requests: only the granted one is written that cycle. The other is written on its later grant, so the final value comes from the later-granted requester.

## Timing
- Outputs are combinational from FSM state, starve_count and requester inputs. Zero-cycle latency: the register file captures data on the same edge that completes the handshake.
- Clear sweep: REGISTER_SIZE-1 cycles after the first edge following reset release. init_done rises in cycle REGISTER_SIZE (i.e. 32 for defaults).
- MC worst-case wait with WB continuously valid: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.
- Reset mid-sweep restarts the sweep at address 1. Reset mid-RUN drops any pending request without a write; requesters re-present after init_done.
- Requests asserted during CLEAR are held off (ready low) and served from the first RUN cycle.

## Structure
- Shared package `register_write_pkg`:
  - state encoding (CLEAR=1'b0, RUN=1'b1);
  - grant encoding (GRANT_NONE, GRANT_WB, GRANT_MC);
  - default STARVE_LIMIT constant.
- One natural sub-module: `write_starvation_counter` (saturating counter with clear/increment, parameterised limit, outputs `starved`). Everything else stays in the top module.

## Test plan
- Reset release, no requests -> addresses 1..31 written with 0 on consecutive cycles; address 0 never written; init_done high in cycle 32.
- RUN: wb_valid with addr 5, data 0xDEADBEEF, mc_valid low -> wb_ready=1, write_enable=1, register 5 reads 0xDEADBEEF next cycle.
- WB and MC valid continuously, STARVE_LIMIT=4 -> grants WB,WB,WB,WB,MC,WB,WB,WB,WB,MC...; starve_count returns to 0 after each MC grant.
- wb_valid with addr 0, data 0x1234 -> wb_ready=1, write_enable=0; register 0 still reads 0.
- Both request addr 7 (WB 0xAAAA0000, MC 0x5555FFFF) with starve_count=0 -> WB written first, MC next cycle; register 7 ends at 0x5555FFFF.
- Reset asserted at sweep address 16, then released -> sweep restarts at address 1; init_done low until 31 fresh clear cycles complete.
